// File: rtl/button_reader.sv
// Four-button debouncer with sticky press events, read through a single 32-bit word.
// Each button is synchronized, debounced by a stability counter, and latches an event on release-to-press.
module button_reader #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn1,
    input  logic        btn2,
    input  logic        btn3,
    input  logic        btn4,
    input  logic        rd_en,
    output logic [31:0] data,
    output logic        irq
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    raw;
    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [3:0]    level;
    logic [3:0]    events;
    logic [3:0]    toggle;
    logic [3:0]    rise;
    logic [CW-1:0] cnt [4];

    // btn1 lands on bit 3 so that each button lines up with its LED.
    assign raw = {btn1, btn2, btn3, btn4};

    always_comb begin
        toggle = '0;
        for (int i = 0; i < 4; i++) begin
            toggle[i] = (s2[i] != level[i]) && (cnt[i] == CNT_MAX);
        end
    end

    assign rise = toggle & ~level;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= '0;
            s2     <= '0;
            level  <= '0;
            events <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (toggle[i]) begin
                    level[i] <= ~level[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
            // A fresh press in the read cycle survives the clear.
            events <= (rd_en ? 4'b0000 : events) | rise;
        end
    end

    assign data = {24'h000000, events, level};
    assign irq  = |events;

endmodule

// File: tb/tb_button_reader.sv
// Scoreboard bench for button_reader with DEBOUNCE_CYCLES=4: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them against data and irq.
module tb_button_reader;

    logic        clk;
    logic        reset;
    logic        btn1;
    logic        btn2;
    logic        btn3;
    logic        btn4;
    logic        rd_en;
    logic [31:0] data;
    logic        irq;

    int cyc;
    int checks;
    int errors;

    typedef struct {
        int          at;
        logic [31:0] value;
        string       name;
    } exp_t;

    exp_t sb[$];

    button_reader #(.DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .btn1  (btn1),
        .btn2  (btn2),
        .btn3  (btn3),
        .btn4  (btn4),
        .rd_en (rd_en),
        .data  (data),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Advance n rising edges, leaving the bench 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] btns, input logic rd, input logic rst);
        btn1  = btns[3];
        btn2  = btns[2];
        btn3  = btns[1];
        btn4  = btns[0];
        rd_en = rd;
        reset = rst;
    endtask

    // Expect data to equal value once k more rising edges have occurred.
    task automatic expect_data(input int k, input logic [31:0] value, input string name);
        exp_t e;
        e.at    = cyc + k;
        e.value = value;
        e.name  = name;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic exp_irq;
        exp_irq = |e.value[7:4];
        checks++;
        if (data !== e.value) begin
            errors++;
            $display("[TB] FAIL %s data: got %08h expected %08h (cycle %0d)", e.name, data, e.value, cyc);
        end
        checks++;
        if (irq !== exp_irq) begin
            errors++;
            $display("[TB] FAIL %s irq: got %b expected %b (cycle %0d)", e.name, irq, exp_irq, cyc);
        end
    endtask

    // Monitor: compares every expectation whose cycle stamp has been reached.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.at == cyc) begin
                checkOutput(e);
            end else begin
                checks++;
                errors++;
                $display("[TB] FAIL %s missed: stamp %0d passed at cycle %0d", e.name, e.at, cyc);
            end
        end
    end

    initial begin
        int wait_cycles;
        cyc    = 0;
        checks = 0;
        errors = 0;
        applyStimulus(4'b0000, 1'b0, 1'b1);
        tick(2);
        expect_data(0, 32'h0, "reset");
        tick(1);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        expect_data(1, 32'h0, "reset_release");
        tick(2);

        // Clean press on btn1: level and event rise five edges after the sampling edge.
        applyStimulus(4'b1000, 1'b0, 1'b0);
        expect_data(5, 32'h00, "press_pre");
        expect_data(6, 32'h88, "press");
        expect_data(7, 32'h88, "press_hold");
        tick(8);
        applyStimulus(4'b1000, 1'b1, 1'b0);
        expect_data(1, 32'h08, "press_read");
        tick(1);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        tick(1);

        // Release of btn1 clears the level without setting an event.
        applyStimulus(4'b0000, 1'b0, 1'b0);
        expect_data(5, 32'h08, "release_pre");
        expect_data(6, 32'h00, "release");
        expect_data(7, 32'h00, "release_hold");
        tick(8);

        // Three-cycle glitch on btn3 never reaches the threshold.
        applyStimulus(4'b0010, 1'b0, 1'b0);
        for (int k = 2; k <= 10; k += 2) expect_data(k, 32'h00, "glitch");
        tick(3);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        tick(8);

        // btn4 press then read clears only the event.
        applyStimulus(4'b0001, 1'b0, 1'b0);
        expect_data(6, 32'h11, "btn4_press");
        tick(7);
        applyStimulus(4'b0001, 1'b1, 1'b0);
        expect_data(1, 32'h01, "read_clear");
        tick(1);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        expect_data(1, 32'h01, "read_clear_hold");
        tick(1);

        // Re-arm event bit 0 with a release and second press of btn4.
        applyStimulus(4'b0000, 1'b0, 1'b0);
        expect_data(6, 32'h00, "btn4_release");
        tick(7);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        expect_data(6, 32'h11, "btn4_repress");
        tick(7);

        // btn2 level rise coincides with a read: bit 6 survives, bit 4 clears.
        applyStimulus(4'b0101, 1'b0, 1'b0);
        expect_data(5, 32'h11, "collision_pre");
        expect_data(6, 32'h45, "collision");
        tick(5);
        applyStimulus(4'b0101, 1'b1, 1'b0);
        tick(1);
        applyStimulus(4'b0101, 1'b0, 1'b0);
        expect_data(1, 32'h45, "collision_hold");
        tick(2);
        applyStimulus(4'b0101, 1'b1, 1'b0);
        expect_data(1, 32'h05, "collision_read");
        tick(1);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        expect_data(6, 32'h00, "release_both");
        tick(8);

        // All four buttons at once produce simultaneous events.
        applyStimulus(4'b1111, 1'b0, 1'b0);
        expect_data(5, 32'h00, "all_pre");
        expect_data(6, 32'hFF, "all_press");
        tick(7);
        applyStimulus(4'b1111, 1'b1, 1'b0);
        expect_data(1, 32'h0F, "all_read");
        tick(1);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        expect_data(6, 32'h00, "all_release");
        tick(8);

        // Reset after two counts on btn2 abandons the partial debounce.
        applyStimulus(4'b0100, 1'b0, 1'b0);
        expect_data(4, 32'h00, "midreset_count");
        expect_data(5, 32'h00, "midreset_at_reset");
        expect_data(10, 32'h00, "midreset_pre");
        expect_data(11, 32'h44, "midreset_press");
        tick(4);
        applyStimulus(4'b0100, 1'b1, 1'b1);
        tick(1);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        tick(8);

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 50) begin
            tick(1);
            wait_cycles++;
        end
        @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL %s never checked: stamp %0d", e.name, e.at);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_reader.md
BUTTON_READER -- requirements
Module: button_reader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles before the debounced level changes (10 ms at 100 MHz); legal range is 1 to 2^24.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports btn1, btn2, btn3, btn4, input, 1 each, raw asynchronous push-button levels, active-high.
REQ-005 SHALL have port rd_en, input, 1, processor read strobe that clears the sticky event bits.
REQ-006 SHALL have port data, output, 32, read word returned to the processor.
REQ-007 SHALL have port irq, output, 1, high while any sticky event bit is set.
REQ-008 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-009 SHALL map each button to the bit position of its matching LED:
- btn1 -> bit 3
- btn2 -> bit 2
- btn3 -> bit 1
- btn4 -> bit 0
- the same per-button index n (0..3) applies to levels and events.
REQ-010 SHALL pass each raw button through a two-flop synchronizer (s1, then s2) before any other logic.
REQ-011 SHALL keep, per button, a debounced level register and a stability counter sized to hold DEBOUNCE_CYCLES-1.
REQ-012 SHALL clear the counter in any cycle where s2 equals the debounced level.
REQ-013 SHALL increment the counter in a cycle where s2 differs from the level and the counter is below DEBOUNCE_CYCLES-1.
REQ-014 SHALL, in a cycle where s2 differs from the level and the counter equals DEBOUNCE_CYCLES-1, toggle the level and clear the counter on that edge; the counter never wraps.
REQ-015 SHALL produce this latency: raw input stable from the edge that samples it into s1 -> debounced level changes exactly DEBOUNCE_CYCLES+1 edges later.
REQ-016 SHALL treat a raw change that reverts before the level toggles as a glitch: counter restarts from 0 and the level is unchanged.
REQ-017 SHALL set sticky event bit n on the edge where debounced level n rises 0->1; releases (1->0) set no event.
REQ-018 SHALL clear all four sticky bits on the edge following a cycle with rd_en=1.
REQ-019 SHALL resolve a rise of level n in the same cycle as rd_en=1 by leaving event bit n set (set wins); other event bits still clear.
REQ-020 SHALL leave a set event bit set when its button is pressed again; there is no counting.
REQ-021 SHALL form data as follows, with data driven combinationally from registers (no added read latency):
- data[3:0] = debounced levels
- data[7:4] = sticky events
- data[31:8] = 0
REQ-022 SHALL drive irq as the OR of data[7:4].
REQ-023 SHALL debounce all four buttons independently; simultaneous presses produce simultaneous events.

Reset
REQ-024 SHALL, on a clock edge with reset=1, clear s1, s2, levels, counters and events.
REQ-025 SHALL hold data=32'h0 and irq=0 after that reset edge until debouncing completes again.
REQ-026 SHALL, when reset is asserted mid-debounce, abandon the partial count; after release, a held button requires the full REQ-015 latency and produces a new event.
REQ-027 SHALL ignore rd_en while reset=1.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 SHALL cover clean press: btn1 0->1 held -> data[3] rises 5 edges after the sampling edge, data[7] rises with it, data=32'h88, irq=1.
REQ-029 SHALL cover glitch: btn3 high for 3 cycles then low -> data stays 32'h0, irq=0.
REQ-030 SHALL cover read-clear: after btn4 press (data=32'h11), pulse rd_en one cycle -> next cycle data=32'h01, irq=0.
REQ-031 SHALL cover a collision: btn2 level rise coincides with an rd_en cycle while event bit 0 is set -> next cycle data[6]=1 and data[4]=0.
REQ-032 SHALL cover release: btn1 held (data=32'h08 after read), release -> data=32'h00 5 edges later, no event set, irq=0.
REQ-033 SHALL cover reset mid-count: btn2 high, reset after 2 counts for 1 cycle, keep btn2 high -> data=32'h0 at reset, then data=32'h44 exactly 5 edges after the first post-reset sampling edge.
